// File: rtl/fusion_operand_sequencer.sv
// Registered, handshaked operand sequencer: captures packed I/W bits and steers them onto
// bit-brick lanes, splitting wide precision pairs into tagged temporal beats.
module fusion_operand_sequencer #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned BEAT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Precision,
  input  logic [LANES-1:0]  I,
  input  logic [LANES-1:0]  W,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANES-1:0]  I_MUX,
  output logic [LANES-1:0]  W_MUX,
  output logic              out_first,
  output logic              out_last,
  output logic [BEAT_W-1:0] out_beat,
  output logic              busy
);

  localparam int unsigned LW = $clog2(LANES);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e              state_q, state_d;
  logic [LANES-1:0]    i_q, i_d, w_q, w_d;
  logic [3:0]          prec_q, prec_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic [1:0]          ip, wp;
  logic [2:0]          lg;
  logic                temporal;
  logic [BEAT_W-1:0]   last_beat;
  logic                at_last;
  logic                accept;

  assign ip       = prec_q[1:0];
  assign wp       = prec_q[3:2];
  assign lg       = {1'b0, ip} + {1'b0, wp};
  assign temporal = (32'(lg) > LW);

  always_comb begin
    last_beat = '0;
    if (temporal) begin
      last_beat = BEAT_W'((32'd1 << (32'(lg) - LW)) - 32'd1);
    end
  end

  assign at_last  = (beat_q == last_beat);
  assign in_ready = (state_q == StIdle) || (out_ready && at_last);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      i_q     <= '0;
      w_q     <= '0;
      prec_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      w_q     <= w_d;
      prec_q  <= prec_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    w_d     = w_q;
    prec_d  = prec_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          i_d     = I;
          w_d     = W;
          prec_d  = Precision;
          beat_d  = '0;
        end
      end
      StIssue: begin
        if (out_ready) begin
          if (!at_last) begin
            beat_d = beat_q + 1'b1;
          end else if (accept) begin
            // Zero-bubble hand-over to the next transaction.
            i_d    = I;
            w_d    = W;
            prec_d = Precision;
            beat_d = '0;
          end else begin
            state_d = StIdle;
            beat_d  = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lane map: spatial packs LANES/G products side by side; temporal walks input slices by beat.
  always_comb begin : lane_map
    int unsigned     g, k;
    logic [LW-1:0]   ii, wi;
    I_MUX = '0;
    W_MUX = '0;
    g     = 0;
    k     = 0;
    ii    = '0;
    wi    = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (!temporal) begin
        g  = l >> lg;
        k  = l & ((32'd1 << lg) - 32'd1);
        ii = LW'((g << ip) + (k >> wp));
        wi = LW'((g << wp) + (k & ((32'd1 << wp) - 32'd1)));
      end else begin
        ii = LW'((32'(beat_q) << (LW - 32'(wp))) + (l >> wp));
        wi = LW'(l & ((32'd1 << wp) - 32'd1));
      end
      I_MUX[l] = i_q[ii];
      W_MUX[l] = w_q[wi];
    end
  end

  assign out_valid = (state_q == StIssue);
  assign out_first = out_valid && (beat_q == '0);
  assign out_last  = out_valid && at_last;
  assign out_beat  = beat_q;
  assign busy      = out_valid && (last_beat != '0) && !at_last;

endmodule

// File: tb/tb_fusion_operand_sequencer.sv
// Directed bench for fusion_operand_sequencer: spatial, temporal, backpressure,
// back-to-back and mid-burst reset cases with hand-computed lane maps.
module tb_fusion_operand_sequencer;

  localparam int unsigned LANES  = 16;
  localparam int unsigned BEAT_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        Precision;
  logic [LANES-1:0]  I, W;
  logic              out_valid;
  logic              out_ready;
  logic [LANES-1:0]  I_MUX, W_MUX;
  logic              out_first, out_last;
  logic [BEAT_W-1:0] out_beat;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  fusion_operand_sequencer #(.LANES(LANES), .BEAT_W(BEAT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Precision (Precision),
    .I         (I),
    .W         (W),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .I_MUX     (I_MUX),
    .W_MUX     (W_MUX),
    .out_first (out_first),
    .out_last  (out_last),
    .out_beat  (out_beat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every output field of one beat.
  task automatic check_beat(input string tag, input logic [15:0] ei, input logic [15:0] ew,
                            input logic ef, input logic el, input int eb, input logic ebusy,
                            input logic erdy);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".imux"},  64'(I_MUX), 64'(ei));
    check({tag, ".wmux"},  64'(W_MUX), 64'(ew));
    check({tag, ".first"}, 64'(out_first), 64'(ef));
    check({tag, ".last"},  64'(out_last), 64'(el));
    check({tag, ".beat"},  64'(out_beat), 64'(eb));
    check({tag, ".busy"},  64'(busy), 64'(ebusy));
    check({tag, ".ready"}, 64'(in_ready), 64'(erdy));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Precision = 4'h0;
    I         = '0;
    W         = '0;
    #2;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.imux",  64'(I_MUX), 64'd0);
    check("rst.wmux",  64'(W_MUX), 64'd0);
    check("rst.first", 64'(out_first), 64'd0);
    check("rst.last",  64'(out_last), 64'd0);
    check("rst.beat",  64'(out_beat), 64'd0);
    check("rst.busy",  64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1b x 1b: straight pass-through.
    in_valid = 1'b1; Precision = 4'b00_00; I = 16'h1234; W = 16'hABCD;
    tick();
    in_valid = 1'b0;
    check_beat("p00", 16'h1234, 16'hABCD, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    tick();
    check("p00.idle", 64'(out_valid), 64'd0);

    // 2b x 2b: four products per beat.
    in_valid = 1'b1; Precision = 4'b01_01; I = 16'h0003; W = 16'h0001;
    tick();
    in_valid = 1'b0;
    check_beat("p11", 16'h000F, 16'h0005, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    tick();

    // 8b x 8b: four temporal beats, backpressure held at beat 1.
    in_valid = 1'b1; Precision = 4'b11_11; I = 16'h0081; W = 16'h00FF;
    tick();
    in_valid = 1'b0; Precision = 4'b00_00;  // must not affect the running set
    check_beat("t.b0", 16'h00FF, 16'hFFFF, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    tick();
    check_beat("t.b1", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_beat("t.hold", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check_beat("t.b2", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    tick();
    check_beat("t.b3", 16'hFF00, 16'hFFFF, 1'b0, 1'b1, 3, 1'b0, 1'b1);
    tick();
    check("t.idle", 64'(out_valid), 64'd0);

    // Back-to-back: 4b x 4b then 1b(W) x 2b(I), no bubble.
    in_valid = 1'b1; Precision = 4'b10_10; I = 16'h0005; W = 16'h0009;
    tick();
    Precision = 4'b00_01; I = 16'hC35A; W = 16'hFFA5;
    check_beat("b2b.a", 16'h0F0F, 16'h9999, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    check_beat("b2b.b", 16'hC35A, 16'hCC33, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    tick();
    check("b2b.idle", 64'(out_valid), 64'd0);

    // Reset during beat 2 of an 8b x 8b set.
    in_valid = 1'b1; Precision = 4'b11_11; I = 16'h0081; W = 16'h00FF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("rb.beat2", 64'(out_beat), 64'd2);
    rst_n = 1'b0;
    #1;
    check("rb.valid", 64'(out_valid), 64'd0);
    check("rb.wmux",  64'(W_MUX), 64'd0);
    check("rb.beat",  64'(out_beat), 64'd0);
    check("rb.busy",  64'(busy), 64'd0);
    check("rb.last",  64'(out_last), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; Precision = 4'b00_00; I = 16'h8001; W = 16'h0F0F;
    tick();
    in_valid = 1'b0;
    check_beat("rb.new", 16'h8001, 16'h0F0F, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fusion_operand_sequencer.md
Name: fusion_operand_sequencer

Overview:
- Registered, handshaked successor to the bit-brick operand fusion mux.
- Maps packed input (I) and weight (W) bits onto LANES 1-bit bit-brick lanes for any precision pair of 1, 2, 4 or 8 bits.
- When a precision pair needs more lanes than exist, it splits the product into several temporal beats and tags them for the downstream accumulator.
- Sits between the operand buffers and the bit-brick array.

Parameters:
- LANES, 16, bit-brick lanes per array; power of two, range 8..64.
- BEAT_W, 3, width of the beat index; must satisfy 2^BEAT_W >= 64/LANES.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  block can accept a transaction this cycle
- Precision  in  4  {WPrec[1:0], IPrec[1:0]}; code c means 2^c bits (00=1b, 01=2b, 10=4b, 11=8b); captured with the transaction
- I  in  LANES  packed input bits, LSB first
- W  in  LANES  packed weight bits, LSB first
- out_valid  out  1  I_MUX/W_MUX valid
- out_ready  in  1  array consumes the beat
- I_MUX  out  LANES  per-lane input bit
- W_MUX  out  LANES  per-lane weight bit
- out_first  out  1  first beat of a product set
- out_last  out  1  last beat of a product set
- out_beat  out  BEAT_W  beat index within the set
- busy  out  1  a multi-beat transaction is in progress

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: out_valid, out_first, out_last, busy = 0; I_MUX, W_MUX, out_beat, beat counter and captured state = 0.
- Derived values: pi = 2^IPrec, pw = 2^WPrec, G = pi*pw.
  - Spatial mode when G <= LANES: NB = 1, NP = LANES/G products per beat.
  - Temporal mode when G > LANES: NB = G/LANES, NP = 1.
- Lane map for lane l and beat t:
  - Spatial: g = l/G, k = l%G; input index = g*pi + k/pw; weight index = g*pw + k%pw.
  - Temporal: input index = t*(pi/NB) + l/pw; weight index = l%pw.
  - I_MUX[l] = captured I[input index]; W_MUX[l] = captured W[weight index].
  - Input bits at or above LANES/pw (spatial) or pi (temporal) are ignored; the same rule applies to unused W bits.
- Handshake and capture:
  - A transaction is accepted on in_valid && in_ready.
  - On acceptance, I, W and Precision are captured; beat 0 appears on the outputs the next cycle (latency 1).
- FSM states:
  - IDLE: out_valid = 0; in_ready = 1.
  - ISSUE: out_valid = 1, showing beat t.
  - On out_ready:
    - If t < NB-1: t increments and the next beat is registered.
    - If t = NB-1 and a new transaction is accepted in the same cycle: stay in ISSUE with t = 0 and the new data (zero-bubble back-to-back).
    - If t = NB-1 and no new transaction is accepted: go to IDLE.
- in_ready = (state == IDLE) || (out_ready && t == NB-1).
- Beat tags: out_first = (t == 0); out_last = (t == NB-1); both are 1 in spatial mode; out_beat = t.
- busy = ISSUE && NB > 1 && !out_last.
- Backpressure: while out_valid && !out_ready, all outputs hold stable and t does not advance.
- Precision changes take effect only at transaction boundaries; a mid-burst change on the input bus has no effect on the current set.
- Reset asserted mid-burst aborts the set; the first transaction after release starts at beat 0.

Test Plan:
- Precision 4'b00_00, I=16'h1234, W=16'hABCD, out_ready=1 -> one cycle later a single beat: I_MUX=16'h1234, W_MUX=16'hABCD, first=last=1.
- Precision 4'b01_01, I=16'h0003, W=16'h0001 -> I_MUX=16'h000F, W_MUX=16'h0005, one beat.
- Precision 4'b11_11, I=16'h0081, W=16'h00FF, out_ready=1 -> four beats:
  - I_MUX sequence = 16'h00FF, 16'h0000, 16'h0000, 16'hFF00.
  - W_MUX = 16'hFFFF on every beat.
  - out_beat = 0..3; first on beat 0, last on beat 3; in_ready=0 during beats 0-2.
- Backpressure: in the 4-beat case, hold out_ready=0 for 3 cycles at beat 1 -> beat 1 outputs held unchanged, then resume at beat 2; no beat lost or duplicated.
- Back-to-back transactions with differing precision (4'b10_10, then 4'b00_01) presented while out_ready=1 -> no idle cycle between sets; the second set uses its own precision.
- Assert rst_n=0 at beat 2 of the 4-beat case -> all outputs 0 immediately; after release, a new 1b x 1b transaction issues correctly with out_beat=0.
